mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single shared data memory.
// Grant in IDLE, hold BUSY until the memory releases (2 cycles min), 1-cycle DONE handshake.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              R0_READ,
  input  logic              R0_WRITE,
  input  logic [ADDR_W-1:0] R0_ADDRESS,
  input  logic [DATA_W-1:0] R0_WRITEDATA,
  output logic [DATA_W-1:0] R0_READDATA,
  output logic              R0_BUSYWAIT,
  input  logic              R1_READ,
  input  logic              R1_WRITE,
  input  logic [ADDR_W-1:0] R1_ADDRESS,
  input  logic [DATA_W-1:0] R1_WRITEDATA,
  output logic [DATA_W-1:0] R1_READDATA,
  output logic              R1_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                last_q;
  logic                busy_seen_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                act0;
  logic                act1;
  logic                gnt_d;
  logic                wr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  assign act0 = R0_READ | R0_WRITE;
  assign act1 = R1_READ | R1_WRITE;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_d = 1'b0;
    if (act0 && act1) gnt_d = ~last_q;
    else              gnt_d = act1;
    addr_d  = gnt_d ? R1_ADDRESS   : R0_ADDRESS;
    wdata_d = gnt_d ? R1_WRITEDATA : R0_WRITEDATA;
    wr_d    = gnt_d ? R1_WRITE     : R0_WRITE;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      busy_seen_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (act0 || act1) begin
            state_q     <= BUSY;
            owner_q     <= gnt_d;
            last_q      <= gnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_write_q <= wr_d;
            mem_read_q  <= ~wr_d;
            busy_seen_q <= 1'b0;
          end
        end
        BUSY: begin
          busy_seen_q <= 1'b1;
          // The first BUSY edge never completes, even if the memory is not busy.
          if (busy_seen_q && !MEM_BUSYWAIT) begin
            state_q     <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) begin
              if (owner_q) rdata1_q <= MEM_READDATA;
              else         rdata0_q <= MEM_READDATA;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign R0_READDATA   = rdata0_q;
  assign R1_READDATA   = rdata1_q;

  assign R0_BUSYWAIT = act0 & ~((state_q == DONE) & (owner_q == 1'b0));
  assign R1_BUSYWAIT = act1 & ~((state_q == DONE) & (owner_q == 1'b1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory of programmable busy stretch.
module tb_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       R0_READ, R0_WRITE, R1_READ, R1_WRITE;
  logic [7:0] R0_ADDRESS, R0_WRITEDATA, R1_ADDRESS, R1_WRITEDATA;
  logic [7:0] R0_READDATA, R1_READDATA;
  logic       R0_BUSYWAIT, R1_BUSYWAIT;
  logic       MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [7:0] MEM_ADDRESS, MEM_WRITEDATA, MEM_READDATA;

  int tests = 0;
  int fails = 0;
  int stretch = 1;
  int cnt = 0;
  int n;
  bit mon_en = 1'b0;
  logic [7:0] mem [256];

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .R0_READ(R0_READ), .R0_WRITE(R0_WRITE), .R0_ADDRESS(R0_ADDRESS),
    .R0_WRITEDATA(R0_WRITEDATA), .R0_READDATA(R0_READDATA), .R0_BUSYWAIT(R0_BUSYWAIT),
    .R1_READ(R1_READ), .R1_WRITE(R1_WRITE), .R1_ADDRESS(R1_ADDRESS),
    .R1_WRITEDATA(R1_WRITEDATA), .R1_READDATA(R1_READDATA), .R1_BUSYWAIT(R1_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  // Memory stays busy for 'stretch' cycles of an access, then completes.
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt < stretch);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    cnt <= (MEM_READ || MEM_WRITE) ? cnt + 1 : 0;
    if (MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      tests++;
      assert ((MEM_READ && MEM_WRITE) === 1'b0)
      else begin
        fails++;
        $error("FAIL rd_wr_excl: MEM_READ=%b MEM_WRITE=%b, required not both high", MEM_READ, MEM_WRITE);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'h3C;
    mem[8'h30] = 8'hA5;
    {R0_READ, R0_WRITE, R1_READ, R1_WRITE} = 4'b0;
    R0_ADDRESS = 8'h00; R0_WRITEDATA = 8'h00;
    R1_ADDRESS = 8'h00; R1_WRITEDATA = 8'h00;

    // Reset state
    #1 RESET = 1'b0;
    #1;
    chk("rst_mem_read",  32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_addr",  32'(MEM_ADDRESS), 32'h00);
    chk("rst_mem_wdata", 32'(MEM_WRITEDATA), 32'h00);
    chk("rst_r0_rdata",  32'(R0_READDATA), 32'h00);
    chk("rst_r1_rdata",  32'(R1_READDATA), 32'h00);
    chk("rst_r0_bw",     32'(R0_BUSYWAIT), 32'd0);
    tick();
    RESET = 1'b1;
    mon_en = 1'b1;
    tick();

    // R0 read of 0x10, 1-cycle memory stretch
    R0_READ = 1'b1; R0_ADDRESS = 8'h10;
    #1 chk("r0rd_bw_idle", 32'(R0_BUSYWAIT), 32'd1);
    tick();
    chk("r0rd_busy1_rd",   32'(MEM_READ), 32'd1);
    chk("r0rd_busy1_addr", 32'(MEM_ADDRESS), 32'h10);
    chk("r0rd_busy1_bw",   32'(R0_BUSYWAIT), 32'd1);
    tick();
    chk("r0rd_busy2_rd",   32'(MEM_READ), 32'd1);
    chk("r0rd_busy2_bw",   32'(R0_BUSYWAIT), 32'd1);
    tick();
    chk("r0rd_done_rd",    32'(MEM_READ), 32'd0);
    chk("r0rd_done_bw",    32'(R0_BUSYWAIT), 32'd0);
    chk("r0rd_rdata",      32'(R0_READDATA), 32'h5A);
    chk("r0rd_r1_rdata",   32'(R1_READDATA), 32'h00);
    R0_READ = 1'b0;
    tick();
    chk("r0rd_hold", 32'(R0_READDATA), 32'h5A);

    // Tie after reset: R0, then R1, then R0 again
    RESET = 1'b0;
    #1 RESET = 1'b1;
    R0_READ = 1'b1; R0_ADDRESS = 8'h10;
    R1_READ = 1'b1; R1_ADDRESS = 8'h11;
    tick();
    chk("tie1_addr",   32'(MEM_ADDRESS), 32'h10);
    chk("tie1_r1_bw",  32'(R1_BUSYWAIT), 32'd1);
    tick();
    chk("tie1_r1_bw2", 32'(R1_BUSYWAIT), 32'd1);
    tick();
    chk("tie1_done_r0_bw", 32'(R0_BUSYWAIT), 32'd0);
    chk("tie1_done_r1_bw", 32'(R1_BUSYWAIT), 32'd1);
    chk("tie1_r0_rdata",   32'(R0_READDATA), 32'h5A);
    tick();
    chk("tie1_idle_rd",    32'(MEM_READ), 32'd0);
    chk("tie1_idle_r1_bw", 32'(R1_BUSYWAIT), 32'd1);
    tick();
    chk("tie2_addr",  32'(MEM_ADDRESS), 32'h11);
    chk("tie2_rd",    32'(MEM_READ), 32'd1);
    tick();
    tick();
    chk("tie2_done_r1_bw", 32'(R1_BUSYWAIT), 32'd0);
    chk("tie2_done_r0_bw", 32'(R0_BUSYWAIT), 32'd1);
    chk("tie2_r1_rdata",   32'(R1_READDATA), 32'h3C);
    tick();
    tick();
    chk("tie3_addr", 32'(MEM_ADDRESS), 32'h10);
    chk("tie3_rd",   32'(MEM_READ), 32'd1);
    R0_READ = 1'b0; R1_READ = 1'b0;
    tick();
    tick();
    tick();

    // R1 writes 0xC3 to 0x20, R0 reads it back
    R1_WRITE = 1'b1; R1_ADDRESS = 8'h20; R1_WRITEDATA = 8'hC3;
    tick();
    chk("r1wr_wr",    32'(MEM_WRITE), 32'd1);
    chk("r1wr_rd",    32'(MEM_READ), 32'd0);
    chk("r1wr_addr",  32'(MEM_ADDRESS), 32'h20);
    chk("r1wr_wdata", 32'(MEM_WRITEDATA), 32'hC3);
    tick();
    tick();
    chk("r1wr_done_bw", 32'(R1_BUSYWAIT), 32'd0);
    chk("r1wr_done_wr", 32'(MEM_WRITE), 32'd0);
    R1_WRITE = 1'b0;
    tick();
    chk("r1wr_idle_addr", 32'(MEM_ADDRESS), 32'h20);
    R0_READ = 1'b1; R0_ADDRESS = 8'h20;
    tick();
    tick();
    tick();
    chk("r0rb_rdata", 32'(R0_READDATA), 32'hC3);
    chk("r0rb_r1_rdata", 32'(R1_READDATA), 32'h3C);
    R0_READ = 1'b0;
    tick();

    // R0 READ+WRITE counts as a write
    R0_READ = 1'b1; R0_WRITE = 1'b1; R0_ADDRESS = 8'h05; R0_WRITEDATA = 8'h77;
    tick();
    chk("rw_wr", 32'(MEM_WRITE), 32'd1);
    chk("rw_rd", 32'(MEM_READ), 32'd0);
    tick();
    tick();
    chk("rw_done_bw", 32'(R0_BUSYWAIT), 32'd0);
    chk("rw_rdata_kept", 32'(R0_READDATA), 32'hC3);
    chk("rw_mem", 32'(mem[8'h05]), 32'h77);
    R0_READ = 1'b0; R0_WRITE = 1'b0;
    tick();

    // Reset in the middle of an R1 read, request held across it
    R1_READ = 1'b1; R1_ADDRESS = 8'h10;
    tick();
    chk("rstb_rd", 32'(MEM_READ), 32'd1);
    #1 RESET = 1'b0;
    #1;
    chk("rstb_rd_off",   32'(MEM_READ), 32'd0);
    chk("rstb_addr",     32'(MEM_ADDRESS), 32'h00);
    chk("rstb_r1_rdata", 32'(R1_READDATA), 32'h00);
    chk("rstb_r0_rdata", 32'(R0_READDATA), 32'h00);
    chk("rstb_r1_bw",    32'(R1_BUSYWAIT), 32'd1);
    tick();
    chk("rstb_hold_rd", 32'(MEM_READ), 32'd0);
    RESET = 1'b1;
    tick();
    chk("rstb_regrant_rd",   32'(MEM_READ), 32'd1);
    chk("rstb_regrant_addr", 32'(MEM_ADDRESS), 32'h10);
    tick();
    tick();
    chk("rstb_r1_rdata2", 32'(R1_READDATA), 32'h5A);
    R1_READ = 1'b0;
    tick();

    // Slow memory, R0 withdraws mid-access
    stretch = 5;
    R0_READ = 1'b1; R0_ADDRESS = 8'h30;
    tick();
    n = 0;
    while (MEM_READ && n < 20) begin
      n++;
      if (n == 2) begin
        R0_READ = 1'b0;
        #1 chk("slow_bw_dropped", 32'(R0_BUSYWAIT), 32'd0);
      end
      tick();
    end
    chk("slow_busy_cycles", 32'(n), 32'd6);
    chk("slow_rdata", 32'(R0_READDATA), 32'hA5);
    chk("slow_r1_rdata", 32'(R1_READDATA), 32'h5A);
    tick();
    chk("slow_no_rd1", 32'(MEM_READ | MEM_WRITE), 32'd0);
    tick();
    tick();
    chk("slow_no_rd2", 32'(MEM_READ | MEM_WRITE), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
